// File: rtl/mcm_filter_seq_pkg.sv
// Shared types and constants for the sequential MCM filter: state encoding,
// coefficient table (index -> constant) and datapath widths.
package mcm_ctrl_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 16;
  localparam int ACC_W    = 18;
  localparam int IDX_W    = 4;
  localparam int NCOEF    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  typedef logic signed [PROD_W-1:0] prod_t;

  // Entry i is the constant that the MCM block multiplies by on output i.
  localparam prod_t COEF_TABLE [NCOEF] = '{
    16'sd53, 16'sd18, 16'sd28, 16'sd20, 16'sd16, 16'sd51,
    16'sd19, 16'sd27, -16'sd2, -16'sd3, 16'sd3,  16'sd11
  };

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(NCOEF);
  endfunction

endpackage

// File: rtl/mcm_filter_seq_if.sv
// Sample-in / result-out streaming bus between the filter and its neighbours.
interface mcm_filter_seq_if;
  import mcm_ctrl_pkg::*;

  logic                s_valid;
  logic [SAMPLE_W-1:0] s_sample;
  logic                s_ready;
  logic                m_valid;
  logic [SAMPLE_W-1:0] m_data;
  logic                m_ready;

  modport master (
    output s_valid, s_sample, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_sample, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/mcm_filter_seq_mcm4.sv
// Multiple-constant multiplier: all twelve coefficient products of one
// unsigned sample, built from shared shift-add terms (no multipliers).
module mcm_filter_seq_mcm4
  import mcm_ctrl_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x_i,
  output prod_t               prod_o [NCOEF]
);

  prod_t x1;
  prod_t x3;
  prod_t x5;
  prod_t x9;

  assign x1 = {{(PROD_W-SAMPLE_W){1'b0}}, x_i};
  assign x3 = (x1 << 1) + x1;
  assign x5 = (x1 << 2) + x1;
  assign x9 = (x1 << 3) + x1;

  // Output order matches COEF_TABLE.
  assign prod_o[0]  = (x1 << 5) + (x1 << 4) + x5;  // 53
  assign prod_o[1]  = x9 << 1;                     // 18
  assign prod_o[2]  = (x1 << 5) - (x1 << 2);       // 28
  assign prod_o[3]  = x5 << 2;                     // 20
  assign prod_o[4]  = x1 << 4;                     // 16
  assign prod_o[5]  = (x3 << 4) + x3;              // 51
  assign prod_o[6]  = (x1 << 4) + x3;              // 19
  assign prod_o[7]  = (x9 << 1) + x9;              // 27
  assign prod_o[8]  = -(x1 << 1);                  // -2
  assign prod_o[9]  = -x3;                         // -3
  assign prod_o[10] = x3;                          // 3
  assign prod_o[11] = x9 + (x1 << 1);              // 11

endmodule

// File: rtl/mcm_filter_seq.sv
// Sequential filter: accumulates NTAPS coefficient-weighted samples, then
// emits a rounded, clipped 8-bit result over a valid/ready stream.
module mcm_filter_seq
  import mcm_ctrl_pkg::*;
#(
  parameter int NTAPS     = 4,
  parameter int RND_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [IDX_W*NTAPS-1:0] sel_vec_i,
  output logic                   busy_o,
  output logic                   sel_err_o,
  mcm_filter_seq_if.slave        bus
);

  localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(2 ** (RND_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] CLIP_MAX = ACC_W'(255);

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [TAP_W-1:0]         tap_q;
  logic [IDX_W*NTAPS-1:0]   sel_q;
  logic                     m_valid_q;
  logic [SAMPLE_W-1:0]      m_data_q;
  logic                     sel_err_q;

  prod_t                    prod_all [NCOEF];
  logic [IDX_W-1:0]         cur_idx;
  prod_t                    cur_prod;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  rnd_d;
  logic signed [ACC_W-1:0]  shr_d;
  logic [SAMPLE_W-1:0]      m_data_d;

  mcm_filter_seq_mcm4 u_mcm_4 (
    .x_i    (bus.s_sample),
    .prod_o (prod_all)
  );

  // 12:1 product select; out-of-range indices contribute nothing.
  always_comb begin
    cur_idx  = sel_q[IDX_W*tap_q +: IDX_W];
    cur_prod = '0;
    if (idx_valid(cur_idx)) begin
      cur_prod = prod_all[cur_idx];
    end
  end

  // Final sum feeds the rounding/clip stage directly so the result register
  // loads on the same edge as the last accept.
  always_comb begin
    sum_d = acc_q + {{(ACC_W-PROD_W){cur_prod[PROD_W-1]}}, cur_prod};
    rnd_d = sum_d + RND_BIAS;
    shr_d = rnd_d >>> RND_SHIFT;
    if (shr_d < 0) begin
      m_data_d = '0;
    end else if (shr_d > CLIP_MAX) begin
      m_data_d = '1;
    end else begin
      m_data_d = shr_d[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      tap_q     <= '0;
      sel_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            sel_q     <= sel_vec_i;
            acc_q     <= '0;
            tap_q     <= '0;
            sel_err_q <= 1'b0;
            state_q   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.s_valid) begin
            acc_q <= sum_d;
            if (!idx_valid(cur_idx)) begin
              sel_err_q <= 1'b1;
            end
            if (tap_q == LAST_TAP) begin
              m_data_q  <= m_data_d;
              m_valid_q <= 1'b1;
              state_q   <= ST_OUT;
            end else begin
              tap_q <= tap_q + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign bus.s_ready = (state_q == ST_ACCUM);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_mcm_filter_seq.sv
// Directed bench for mcm_filter_seq: stimulus pushes hand-computed results
// into a queue, a negedge monitor pops and compares on each output handshake.
module tb_mcm_filter_seq;
  import mcm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sel_vec = '0;
  logic        busy;
  logic        sel_err;

  mcm_filter_seq_if bus_if ();

  mcm_filter_seq #(.NTAPS(4), .RND_SHIFT(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .sel_vec_i (sel_vec),
    .busy_o    (busy),
    .sel_err_o (sel_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q [$];  // {sel_err, m_data}
  logic [8:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.m_valid && bus_if.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_data", int'(bus_if.m_data), int'(mon_e[7:0]));
        chk("sel_err", int'(sel_err), int'(mon_e[8]));
      end
    end
  end

  // Called one time unit after a rising edge; returns the same way, one
  // cycle after the output handshake, so a following job starts from IDLE.
  task automatic run_job(input string tag, input logic [15:0] sel,
                         input logic [31:0] smp, input logic [3:0] gaps,
                         input int exp_data, input logic exp_err,
                         input int delay);
    exp_q.push_back({exp_err, 8'(exp_data)});
    start   = 1'b1;
    sel_vec = sel;
    @(posedge clk); #1;
    start   = 1'b0;
    sel_vec = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      if (gaps[k]) begin
        bus_if.s_valid  = 1'b0;
        bus_if.s_sample = 8'hFF;
        @(negedge clk);
        chk({tag, "_gap_busy"}, int'(busy), 1);
        @(posedge clk); #1;
      end
      if (k == 3) chk({tag, "_mvalid_early"}, int'(bus_if.m_valid), 0);
      bus_if.s_valid  = 1'b1;
      bus_if.s_sample = smp[8*k +: 8];
      @(negedge clk);
      chk({tag, "_s_ready"}, int'(bus_if.s_ready), 1);
      @(posedge clk); #1;
      bus_if.s_valid = 1'b0;
    end
    chk({tag, "_latency"}, int'(bus_if.m_valid), 1);
    for (int d = 0; d < delay; d++) begin
      start   = (d == 2);
      sel_vec = (d == 2) ? 16'h0000 : 16'hFFFF;
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(bus_if.m_valid), 1);
      chk({tag, "_hold_data"}, int'(bus_if.m_data), exp_data);
      chk({tag, "_hold_s_ready"}, int'(bus_if.s_ready), 0);
      chk({tag, "_hold_busy"}, int'(busy), 1);
      @(posedge clk); #1;
    end
    start          = 1'b0;
    bus_if.m_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.m_ready = 1'b0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_mvalid"}, int'(bus_if.m_valid), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_s_ready"}, int'(bus_if.s_ready), 0);
    chk({tag, "_m_valid"}, int'(bus_if.m_valid), 0);
    chk({tag, "_m_data"}, int'(bus_if.m_data), 0);
    chk({tag, "_sel_err"}, int'(sel_err), 0);
  endtask

  localparam logic [31:0] MIXED = {8'd40, 8'd30, 8'd20, 8'd10};

  initial begin
    bus_if.s_valid  = 1'b0;
    bus_if.s_sample = '0;
    bus_if.m_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Samples presented while IDLE must be ignored.
    bus_if.s_valid  = 1'b1;
    bus_if.s_sample = 8'd200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_s_ready", int'(bus_if.s_ready), 0);
      @(posedge clk); #1;
    end
    bus_if.s_valid = 1'b0;

    run_job("uniform", 16'h4444, {4{8'd100}}, 4'b0000, 100, 1'b0, 0);
    run_job("mixed",   16'h3210, MIXED,       4'b0000, 40,  1'b0, 0);
    run_job("clip_lo", 16'h8888, {4{8'd255}}, 4'b0000, 0,   1'b0, 1);
    run_job("clip_hi", 16'h0000, {4{8'd255}}, 4'b0000, 255, 1'b0, 0);
    run_job("backpr",  16'h3210, MIXED,       4'b0000, 40,  1'b0, 5);
    run_job("badidx",  16'h444C, {4{8'd50}},  4'b1010, 38,  1'b1, 2);
    chk("sel_err_sticky", int'(sel_err), 1);

    // Abort a job with reset after two accepts.
    start   = 1'b1;
    sel_vec = 16'h444C;
    @(posedge clk); #1;
    start           = 1'b0;
    bus_if.s_valid  = 1'b1;
    bus_if.s_sample = 8'd50;
    repeat (2) @(posedge clk);
    #1;
    bus_if.s_valid = 1'b0;
    chk("abort_busy", int'(busy), 1);
    chk("abort_err_set", int'(sel_err), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_job("after_rst", 16'h3210, MIXED, 4'b0000, 40, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
